wr_ptr_full_ctrl: RTL

- Parametrised write-side pointer and flag controller for the async FIFO, clocked in the write domain.
- Keeps the binary and Gray write pointers and drives the RAM write address.
- Compares the write pointer against the read Gray pointer, which arrives already synchronised into this domain.
- Generates full, almost-full, a fill level and an overflow indication. Successor to the fixed 4-bit write-pointer/full block.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/gray2bin_conv.sv | 13 +
 rtl/wr_ptr_full_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth calculation, Gray/binary conversion, counter width.
package fifo_pkg;

    localparam int unsigned OVF_CNT_W = 8;
    // Widest pointer supported (ADDR_W up to 12 plus the wrap bit); narrower values are zero-extended.
    localparam int unsigned MAX_PTR_W = 13;

    function automatic int unsigned depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Width-parametrised Gray-to-binary converter (combinational XOR prefix from the MSB).
module gray2bin_conv #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-side pointer, full/almost-full, level and overflow control for the async FIFO.
// Optional saturating drop counter enabled by defining WPTR_OVF_CNT_EN.
module wr_ptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_en,
    input  logic [ADDR_W:0]   rd_ptr_gray_sync,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W:0]   w_ptr_bin,
    output logic [ADDR_W:0]   w_ptr_gray,
    output logic              w_inc,
    output logic              full,
    output logic              w_afull,
    output logic [ADDR_W:0]   w_level,
    output logic              w_ovf
`ifdef WPTR_OVF_CNT_EN
    ,
    input  logic                 w_ovf_clr,
    output logic [OVF_CNT_W-1:0] w_ovf_cnt
`endif
);

    localparam int unsigned PTR_W       = ADDR_W + 1;
    localparam int unsigned AFULL_CLAMP = (AFULL_THRESH > depth(ADDR_W)) ? depth(ADDR_W)
                                                                        : AFULL_THRESH;
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_CLAMP);

    logic [PTR_W-1:0] bin_nxt;
    logic [PTR_W-1:0] gray_nxt;
    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] level_nxt;
    logic [PTR_W-1:0] full_cmp;
    logic             full_nxt;
    logic             afull_nxt;

    gray2bin_conv #(
        .W (PTR_W)
    ) u_rd_g2b (
        .gray (rd_ptr_gray_sync),
        .bin  (rd_bin)
    );

    assign w_inc  = w_en & ~full;
    assign w_addr = w_ptr_bin[ADDR_W-1:0];

    always_comb begin
        bin_nxt   = w_ptr_bin + PTR_W'(w_inc);
        gray_nxt  = PTR_W'(bin2gray(MAX_PTR_W'(bin_nxt)));
        // Full when the write pointer is one lap ahead: top two Gray bits differ, rest equal.
        full_cmp  = {~rd_ptr_gray_sync[ADDR_W:ADDR_W-1], rd_ptr_gray_sync[ADDR_W-2:0]};
        full_nxt  = (gray_nxt == full_cmp);
        level_nxt = bin_nxt - rd_bin;
        afull_nxt = (level_nxt >= AFULL_LVL);
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_ptr_bin  <= '0;
            w_ptr_gray <= '0;
            full       <= 1'b0;
            w_afull    <= 1'b0;
            w_level    <= '0;
            w_ovf      <= 1'b0;
        end else begin
            w_ptr_bin  <= bin_nxt;
            w_ptr_gray <= gray_nxt;
            full       <= full_nxt;
            w_afull    <= afull_nxt;
            w_level    <= level_nxt;
            w_ovf      <= w_en & full;
        end
    end

`ifdef WPTR_OVF_CNT_EN
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            w_ovf_cnt <= '0;
        end else if (w_ovf_clr) begin
            w_ovf_cnt <= '0;
        end else if (w_en && full && (w_ovf_cnt != {OVF_CNT_W{1'b1}})) begin
            w_ovf_cnt <= w_ovf_cnt + 1'b1;
        end
    end
`endif

endmodule
